// File: rtl/paraacc_pkg.sv
// Shared constants, state type and saturation limits for the paraacc_16p16 accumulation stage.
package paraacc_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam logic signed [ACC_W-1:0] LANE_MAX = {{(ACC_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LANE_MIN = {{(ACC_W-LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};

  // A programmed length of zero behaves as a single-beat frame.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/paraacc_lane.sv
// One lane: signed accumulator plus conversion of the running frame sum to LANE_W.
// Optional clamping to the LANE_W signed range is built when SATURATE_EN is defined.
module paraacc_lane
  import paraacc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_add,
  input  logic [LANE_W-1:0] i_din,
  output logic [LANE_W-1:0] o_res
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_din_ext;
  logic signed [ACC_W-1:0] w_next;

  assign w_din_ext = {{(ACC_W-LANE_W){i_din[LANE_W-1]}}, i_din};
  // o_res is derived from the sum including the current beat, so the completing beat is counted.
  assign w_next    = i_load ? w_din_ext : (r_acc + w_din_ext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_load || i_add) begin
      r_acc <= w_next;
    end
  end

`ifdef SATURATE_EN
  always_comb begin
    if (w_next > LANE_MAX) begin
      o_res = LANE_MAX[LANE_W-1:0];
    end else if (w_next < LANE_MIN) begin
      o_res = LANE_MIN[LANE_W-1:0];
    end else begin
      o_res = w_next[LANE_W-1:0];
    end
  end
`else
  assign o_res = w_next[LANE_W-1:0];
`endif

endmodule

// File: rtl/paraacc_16p16.sv
// Per-lane frame accumulator behind the 16-lane adder with a valid/ready output holding register.
// Build option: define SATURATE_EN to clamp lane sums instead of wrapping.
//
// state | meaning
// IDLE  | no partial frame; next valid beat starts a frame
// ACC   | frame partially accumulated, waiting for more beats
module paraacc_16p16
  import paraacc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic                    in_v,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic                    busy,
  output logic                    ovf_err
);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [LEN_W-1:0]          r_cnt;
  logic [LEN_W-1:0]          r_len;
  logic [LANES*LANE_W-1:0]   r_out_data;
  logic                      r_out_v;
  logic                      r_ovf;
  logic                      w_load;
  logic                      w_add;
  logic                      w_done;
  logic                      w_ohr_free;
  logic [LANES*LANE_W-1:0]   w_res;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    paraacc_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_add  (w_add),
      .i_din  (in_data[g*LANE_W +: LANE_W]),
      .o_res  (w_res[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_v) begin
          w_load = 1'b1;
          if (eff_len(cfg_len) == LEN_W'(1)) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (in_v) begin
          w_add = 1'b1;
          if ((r_cnt + LEN_W'(1)) == r_len) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt <= LEN_W'(1);
        r_len <= eff_len(cfg_len);
      end else if (w_add) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  // The OHR can take a new frame when empty or when its current frame leaves this cycle.
  assign w_ohr_free = !r_out_v || out_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data <= '0;
      r_out_v    <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_done && w_ohr_free) begin
      r_out_data <= w_res;
      r_out_v    <= 1'b1;
    end else begin
      if (w_done) begin
        r_ovf <= 1'b1;
      end
      if (r_out_v && out_rdy) begin
        r_out_v <= 1'b0;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_v    = r_out_v;
  assign busy     = (r_state == ACC);
  assign ovf_err  = r_ovf;

endmodule

// File: doc/paraacc_16p16.md
# paraacc_16p16

Downstream accumulation stage for the 16-lane parallel adder array. It consumes the adder's 256-bit result bus, which carries 16 signed 16-bit lanes, together with its result-valid strobe. Per lane, it sums a configurable number of consecutive valid beats into a frame total. Each completed frame is presented on a registered valid/ready output holding register. The adder has no backpressure, so this block never stalls its input; it flags lost frames instead.

## Interface
- LANES, 16, number of parallel lanes
- LANE_W, 16, lane width in bits (signed two's complement)
- ACC_W, 24, internal per-lane accumulator width (≥ LANE_W + LEN_W)
- LEN_W, 8, width of the frame-length configuration

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low
- in_data  in  LANES*LANE_W  lane results; lane i is bits [i*16+15 : i*16]
- in_v  in  1  input beat valid, one beat per cycle, no ready
- cfg_len  in  LEN_W  beats per frame; sampled only on the first beat of a frame; 0 is treated as 1
- out_data  out  LANES*LANE_W  frame sums, same lane packing as in_data
- out_v  out  1  out_data valid; held until accepted
- out_rdy  in  1  consumer accepts when out_v && out_rdy
- busy  out  1  high while a frame is partially accumulated (state ACC)
- ovf_err  out  1  sticky: a completed frame was dropped

## Operation
- State machine with two states, IDLE and ACC. There is a separate output holding register (OHR) with flag out_v.
- IDLE with in_v:
  - acc[i] = sign-extend(lane i); cnt = 1; len = max(cfg_len, 1).
  - If len == 1, the frame completes this cycle and the state stays IDLE; otherwise go to ACC.
- ACC with in_v:
  - acc[i] += sign-extend(lane i); cnt += 1.
  - When cnt+1 == len, the frame completes and the state returns to IDLE.
- ACC without in_v: hold; there is no timeout.
- Completion:
  - The final sum includes the completing beat.
  - It is converted to LANE_W per lane (see Configuration) and loaded into the OHR.
- OHR rules:
  - Load is allowed if !out_v, or if out_v && out_rdy in the same cycle. In the second case, out_v stays 1 and new data replaces the old.
  - If completion occurs while out_v && !out_rdy, the new frame is discarded, the OHR is unchanged, and ovf_err is set to 1 until reset.
  - Accumulation is never blocked by the OHR.
- Accepting (out_v && out_rdy with no load) clears out_v next cycle.
- ACC_W never overflows for len ≤ 255; no internal wrap handling is needed.

## Timing
- Reset values: out_data = 0, out_v = 0, busy = 0, ovf_err = 0; state IDLE, acc = 0, cnt = 0.
- Latency: completing beat at cycle t → out_v = 1 with its sum at cycle t+1.
- Back-to-back frames: a new frame may start in the cycle immediately after completion.
- With len = 1, every in_v produces a result one cycle later, giving a throughput of one frame per cycle if out_rdy is held high.
- cfg_len changes mid-frame are ignored.
- Reset mid-frame aborts the partial frame with no output; ovf_err is cleared.

## Configuration
- SATURATE_EN defined:
  - Each lane's frame sum is clamped to [-32768, 32767].
  - Results above the range give 16'h7FFF; results below give 16'h8000.
- SATURATE_EN undefined:
  - Each lane outputs acc[i][LANE_W-1:0], i.e. two's-complement wrap.
  - The saturation logic is absent.

## Structure
- Shared package paraacc_pkg holds:
  - the constants LANES, LANE_W, ACC_W, LEN_W;
  - the state enum type (IDLE, ACC);
  - the saturation limit constants LANE_MAX and LANE_MIN.
- One sub-module, paraacc_lane, is instantiated LANES times. Each instance contains:
  - the accumulator register, with a load/add control from the top;
  - the optional saturation function, producing the LANE_W result.
- The top level holds the FSM, cnt, the OHR, and ovf_err.

## Test plan
- Frame accumulation: cfg_len = 4; lane 0 = 1, 2, 3, 4 and lane 15 = -5 on four consecutive beats; out_rdy = 1 → one out_v pulse the cycle after beat 4, with lane 0 = 10 and lane 15 = -20.
- Saturation:
  - Stimulus: cfg_len = 3; all lanes = 16'h7000 (28672) on three beats.
  - With SATURATE_EN: all lanes = 16'h7FFF.
  - Without SATURATE_EN: all lanes = 16'h5000.
- Streaming with zero length: cfg_len = 0; 5 beats with values 1..5 in lane 3; out_rdy = 1 → five consecutive out_v cycles, lane 3 = 1..5, busy never asserted.
- Backpressure and overflow:
  - Stimulus: cfg_len = 1; out_rdy = 0; beats A then B.
  - Required: out_data stays A, ovf_err = 1 from the cycle after B.
  - Then raise out_rdy: A is accepted, out_v = 0, ovf_err stays 1.
- Simultaneous accept and load: cfg_len = 2; OHR holds X; out_rdy = 1 in the same cycle a frame Y completes → next cycle out_v = 1 with Y, ovf_err = 0.
- Reset mid-frame: cfg_len = 4; 2 beats; assert rst asynchronously between clock edges → immediately busy = 0, out_v = 0. After release, a new 4-beat frame sums from zero.
